// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Address/data widths and the arbiter state encoding.
package dmem_arb_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOST_BURST = 2'd1,
    HOST_DONE  = 2'd2,
    CORE_RUN   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_burst_counter.sv
// Host burst address generator.
// Wrapping address plus remaining-beat count; length 0 means 2^AW beats.
module burst_counter #(
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load,
  input  logic [AW-1:0] LoadAddr,
  input  logic [AW-1:0] LoadLen,
  input  logic          Step,
  output logic [AW-1:0] Addr,
  output logic          Last
);

  logic [AW:0] remaining;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Addr      <= '0;
      remaining <= '0;
    end else if (Load) begin
      Addr      <= LoadAddr;
      remaining <= (LoadLen == '0) ? {1'b1, {AW{1'b0}}}
                                   : {1'b0, LoadLen};
    end else if (Step) begin
      Addr      <= Addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign Last = (remaining == (AW+1)'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core and a host burst port.
// Host bursts run only while the core is idle; starts wait for bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          StartIn,
  output logic          StartOut,
  input  logic          CoreAck,
  input  logic [AW-1:0] CoreAddr,
  input  logic          CoreWrEn,
  input  logic [DW-1:0] CoreWrData,
  input  logic          HostReq,
  input  logic          HostWr,
  input  logic [AW-1:0] HostAddr,
  input  logic [AW-1:0] HostLen,
  input  logic [DW-1:0] HostWrData,
  output logic          HostGnt,
  output logic          HostRdValid,
  output logic [DW-1:0] HostRdData,
  output logic          HostDone,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData
);

  arb_state_t    state;
  arb_state_t    nextState;
  logic          pending;
  logic          burstWr;
  logic          startReq;
  logic          loadBurst;
  logic          beat;
  logic          rdBeat;
  logic [AW-1:0] burstAddr;
  logic          burstLast;

  assign startReq  = StartIn | pending;
  assign loadBurst = (state == IDLE) && !startReq && HostReq;
  assign beat      = (state == HOST_BURST);
  assign rdBeat    = beat && !burstWr;

  burst_counter #(.AW(AW)) u_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (loadBurst),
    .LoadAddr (HostAddr),
    .LoadLen  (HostLen),
    .Step     (beat),
    .Addr     (burstAddr),
    .Last     (burstLast)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (startReq)     nextState = CORE_RUN;
        else if (HostReq) nextState = HOST_BURST;
      end
      HOST_BURST: if (burstLast) nextState = HOST_DONE;
      HOST_DONE:  nextState = IDLE;
      CORE_RUN:   if (CoreAck) nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      burstWr     <= 1'b0;
      HostRdValid <= 1'b0;
      HostRdData  <= '0;
    end else begin
      state       <= nextState;
      HostRdValid <= rdBeat;
      if (loadBurst) burstWr <= HostWr;
      if (rdBeat) HostRdData <= MemRdData;
      // A start arriving mid-burst waits; it launches from IDLE.
      if (state == IDLE)
        pending <= 1'b0;
      else if (StartIn && state != CORE_RUN)
        pending <= 1'b1;
    end
  end

  assign StartOut = !Reset && (state == IDLE) && startReq;
  assign HostGnt  = beat;
  assign HostDone = (state == HOST_DONE);
  assign Busy     = (state != IDLE);

  always_comb begin
    MemAddr   = CoreAddr;
    MemWrEn   = 1'b0;
    MemWrData = CoreWrData;
    unique case (state)
      HOST_BURST: begin
        MemAddr   = burstAddr;
        MemWrEn   = burstWr;
        MemWrData = HostWrData;
      end
      HOST_DONE: MemAddr = burstAddr;
      CORE_RUN:  MemWrEn = CoreWrEn;
      default:   MemWrEn = 1'b0;
    endcase
    if (Reset) MemWrEn = 1'b0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter.
// Reference memory and burst timing are modelled from the burst rules.
module tb_dmem_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       StartIn;
  logic       StartOut;
  logic       CoreAck;
  logic [7:0] CoreAddr;
  logic       CoreWrEn;
  logic [7:0] CoreWrData;
  logic       HostReq;
  logic       HostWr;
  logic [7:0] HostAddr;
  logic [7:0] HostLen;
  logic [7:0] HostWrData;
  logic       HostGnt;
  logic       HostRdValid;
  logic [7:0] HostRdData;
  logic       HostDone;
  logic       Busy;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic [7:0] mem     [256];
  logic [7:0] refMem  [256];
  logic [7:0] initVal [256];
  logic [7:0] fixedData [4];
  logic       memInit;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .StartIn    (StartIn),
    .StartOut   (StartOut),
    .CoreAck    (CoreAck),
    .CoreAddr   (CoreAddr),
    .CoreWrEn   (CoreWrEn),
    .CoreWrData (CoreWrData),
    .HostReq    (HostReq),
    .HostWr     (HostWr),
    .HostAddr   (HostAddr),
    .HostLen    (HostLen),
    .HostWrData (HostWrData),
    .HostGnt    (HostGnt),
    .HostRdValid(HostRdValid),
    .HostRdData (HostRdData),
    .HostDone   (HostDone),
    .Busy       (Busy),
    .MemAddr    (MemAddr),
    .MemWrEn    (MemWrEn),
    .MemWrData  (MemWrData),
    .MemRdData  (MemRdData)
  );

  // DataMem stand-in: combinational read, synchronous write
  always @(posedge Clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal[i];
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
    end
  end
  assign MemRdData = mem[MemAddr];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic runBurst(input bit wr, input logic [7:0] addr,
                          input logic [7:0] len, input int startBeat,
                          input bit fixed);
    int beats;
    logic [7:0] a;
    beats = (len == 8'd0) ? 256 : int'(len);
    HostReq = 1'b1;
    HostWr = wr;
    HostAddr = addr;
    HostLen = len;
    settle();
    check("idle_gnt", HostGnt, 0);
    check("idle_start", StartOut, 0);
    nextCycle();
    HostReq = 1'b0;
    HostWr = 1'($urandom);
    HostAddr = 8'($urandom);
    HostLen = 8'($urandom);
    for (int k = 1; k <= beats; k++) begin
      a = addr + 8'(k - 1);
      StartIn = (k == startBeat);
      HostWrData = fixed ? fixedData[k-1] : 8'($urandom);
      settle();
      check("beat_gnt", HostGnt, 1);
      check("beat_addr", MemAddr, a);
      check("beat_wren", MemWrEn, wr);
      check("beat_done", HostDone, 0);
      check("beat_start", StartOut, 0);
      check("beat_busy", Busy, 1);
      if (wr) begin
        check("beat_wrdata", MemWrData, HostWrData);
        check("beat_rdvalid", HostRdValid, 0);
        refMem[a] = HostWrData;
      end else begin
        check("rd_valid", HostRdValid, (k > 1));
        if (k > 1) check("rd_data", HostRdData, refMem[8'(a - 8'd1)]);
      end
      nextCycle();
    end
    StartIn = 1'b0;
    settle();
    check("done_pulse", HostDone, 1);
    check("done_gnt", HostGnt, 0);
    check("done_wren", MemWrEn, 0);
    check("done_rdvalid", HostRdValid, !wr);
    if (!wr)
      check("done_rddata", HostRdData, refMem[8'(addr + 8'(beats - 1))]);
    nextCycle();
    settle();
    check("post_busy", Busy, 0);
    check("post_done", HostDone, 0);
    check("post_rdvalid", HostRdValid, 0);
    check("post_start", StartOut, (startBeat != 0));
  endtask

  task automatic coreRun(input int waitCycles);
    for (int i = 0; i < waitCycles; i++) begin
      CoreWrEn = 1'b0;
      settle();
      check("core_busy", Busy, 1);
      check("core_gnt", HostGnt, 0);
      check("core_wren0", MemWrEn, 0);
      nextCycle();
    end
    CoreAddr = 8'h20;
    CoreWrEn = 1'b1;
    CoreWrData = 8'h5A;
    CoreAck = 1'b1;
    settle();
    check("core_addr", MemAddr, 8'h20);
    check("core_wren", MemWrEn, 1);
    check("core_wrdata", MemWrData, 8'h5A);
    refMem[8'h20] = 8'h5A;
    nextCycle();
    CoreAck = 1'b0;
    CoreWrEn = 1'b0;
    settle();
    check("core_exit_busy", Busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    StartIn = 1'b0;
    CoreAck = 1'b0;
    CoreAddr = 8'h00;
    CoreWrEn = 1'b0;
    CoreWrData = 8'h00;
    HostReq = 1'b0;
    HostWr = 1'b0;
    HostAddr = 8'h00;
    HostLen = 8'h00;
    HostWrData = 8'h00;
    fixedData = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 256; i++) begin
      initVal[i] = 8'($urandom);
      refMem[i] = initVal[i];
    end
    memInit = 1'b1;
    repeat (3) nextCycle();
    memInit = 1'b0;
    Reset = 1'b0;
    settle();
    check("rst_start", StartOut, 0);
    check("rst_gnt", HostGnt, 0);
    check("rst_rdvalid", HostRdValid, 0);
    check("rst_rddata", HostRdData, 0);
    check("rst_done", HostDone, 0);
    check("rst_busy", Busy, 0);
    check("rst_wren", MemWrEn, 0);
    nextCycle();

    // 4-beat write, then read back
    runBurst(1'b1, 8'h10, 8'd4, 0, 1'b1);
    nextCycle();
    runBurst(1'b0, 8'h10, 8'd4, 0, 1'b0);
    nextCycle();

    // 256-beat wrapping write, read across the wrap
    runBurst(1'b1, 8'hFE, 8'd0, 0, 1'b0);
    nextCycle();
    runBurst(1'b0, 8'hFC, 8'd6, 0, 1'b0);
    nextCycle();

    // start during beat 2 is deferred
    runBurst(1'b1, 8'h60, 8'd4, 2, 1'b0);
    CoreAddr = 8'h30;
    CoreWrEn = 1'b1;
    CoreWrData = 8'h77;
    #1;
    check("idle_core_wren", MemWrEn, 0);
    nextCycle();
    CoreWrEn = 1'b0;
    coreRun(2);
    nextCycle();

    // start beats a simultaneous host request
    HostReq = 1'b1;
    HostWr = 1'b1;
    HostAddr = 8'h80;
    HostLen = 8'd3;
    StartIn = 1'b1;
    settle();
    check("tie_start", StartOut, 1);
    check("tie_gnt", HostGnt, 0);
    nextCycle();
    StartIn = 1'b0;
    coreRun(3);
    runBurst(1'b1, 8'h80, 8'd3, 0, 1'b0);
    nextCycle();

    for (int r = 0; r < 6; r++) begin
      runBurst(1'($urandom_range(0, 1)), 8'($urandom),
               8'($urandom_range(1, 12)), 0, 1'b0);
      nextCycle();
    end

    // reset during beat 3 of an 8-beat write
    HostReq = 1'b1;
    HostWr = 1'b1;
    HostAddr = 8'h40;
    HostLen = 8'd8;
    nextCycle();
    HostReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      HostWrData = 8'($urandom);
      StartIn = (k == 1);
      refMem[8'h40 + 8'(k)] = HostWrData;
      nextCycle();
    end
    StartIn = 1'b0;
    HostWrData = 8'($urandom);
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    settle();
    check("mid_rst_start", StartOut, 0);
    check("mid_rst_gnt", HostGnt, 0);
    check("mid_rst_rdvalid", HostRdValid, 0);
    check("mid_rst_rddata", HostRdData, 0);
    check("mid_rst_done", HostDone, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_wren", MemWrEn, 0);
    repeat (10) nextCycle();
    settle();
    check("mid_rst_idle_busy", Busy, 0);
    check("mid_rst_idle_start", StartOut, 0);

    for (int i = 0; i < 256; i++) begin
      if (i != 8'h42) check("mem_content", mem[i], refMem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
